// File: rtl/tl_ul_sram_slave.sv
// tl_ul_sram_slave: single-beat TileLink-UL responder backed by a word-addressed SRAM
module tl_ul_sram_slave #(
    parameter int W     = 4,
    parameter int A     = 32,
    parameter int Z     = 2,
    parameter int O     = 1,
    parameter int I     = 1,
    parameter int DEPTH = 1024
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic [2:0]     a_opcode_i,
    input  logic [2:0]     a_param_i,
    input  logic [Z-1:0]   a_size_i,
    input  logic [O-1:0]   a_source_i,
    input  logic [A-1:0]   a_address_i,
    input  logic [W-1:0]   a_mask_i,
    input  logic [8*W-1:0] a_data_i,
    input  logic           a_valid_i,
    output logic           a_ready_o,
    output logic [2:0]     d_opcode_o,
    output logic [1:0]     d_param_o,
    output logic [Z-1:0]   d_size_o,
    output logic [O-1:0]   d_source_o,
    output logic [I-1:0]   d_sink_o,
    output logic [8*W-1:0] d_data_o,
    output logic           d_error_o,
    output logic           d_valid_o,
    input  logic           d_ready_i
);
    localparam int LW = $clog2(W);
    localparam int DW = $clog2(DEPTH);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t         state, state_next;
    logic [8*W-1:0] mem [DEPTH];
    logic [W-1:0]   exp_mask;
    logic [DW-1:0]  idx;
    logic           is_full, is_part, is_get, err, accept, wr;
    logic           bad_op, bad_size, bad_align, bad_range, bad_mask;
    int             nbytes, lane;
    logic           unused_param;

    assign unused_param = ^a_param_i;
    assign idx          = a_address_i[LW +: DW];
    assign is_full      = a_opcode_i == 3'd0;
    assign is_part      = a_opcode_i == 3'd1;
    assign is_get       = a_opcode_i == 3'd4;
    assign d_valid_o    = state == FULL;
    assign a_ready_o    = rst_ni & (~d_valid_o | d_ready_i);
    assign accept       = a_valid_i & a_ready_o;
    assign wr           = accept & ~err & (is_full | is_part);
    assign d_param_o    = '0;
    assign d_sink_o     = '0;

    // Request legality: opcode, size, alignment, range and lane-mask checks
    always_comb begin
        nbytes = 1 << a_size_i;
        lane   = int'(a_address_i & A'(W - 1));
        for (int j = 0; j < W; j++) exp_mask[j] = (j >= lane) && (j < lane + nbytes);
        bad_op    = ~(is_full | is_part | is_get);
        bad_size  = int'(a_size_i) > LW;
        bad_align = |(a_address_i & (A'(nbytes) - A'(1)));
        bad_range = |(a_address_i >> (LW + DW));
        bad_mask  = (is_get | is_full) ? (a_mask_i != exp_mask) :
                    is_part ? |(a_mask_i & ~exp_mask) : 1'b0;
        err       = bad_op | bad_size | bad_align | bad_range | bad_mask;
    end

    // Next state: a new accept refills, a drain without accept empties
    always_comb begin
        state_next = accept ? FULL : (d_ready_i ? EMPTY : state);
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= EMPTY;
        else         state <= state_next;
    end

    // Byte-lane SRAM write on the accepting edge; contents survive reset
    always_ff @(posedge clk_i) begin
        for (int j = 0; j < W; j++)
            if (wr && a_mask_i[j]) mem[idx][8*j +: 8] <= a_data_i[8*j +: 8];
    end

    // Response registers load on accept and otherwise hold
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            d_opcode_o <= '0;
            d_size_o   <= '0;
            d_source_o <= '0;
            d_data_o   <= '0;
            d_error_o  <= 1'b0;
        end else if (accept) begin
            d_opcode_o <= is_get ? 3'd1 : 3'd0;
            d_size_o   <= a_size_i;
            d_source_o <= a_source_i;
            d_data_o   <= (is_get && !err) ? mem[idx] : '0;
            d_error_o  <= err;
        end
    end
endmodule

// File: tb/tb_tl_ul_sram_slave.sv
// tb_tl_ul_sram_slave: directed-vector bench for the TileLink-UL SRAM responder
module tb_tl_ul_sram_slave;
    logic        clk;
    logic        rst_n;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [0:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        a_valid;
    logic        a_ready;
    logic [2:0]  d_opcode;
    logic [1:0]  d_param;
    logic [1:0]  d_size;
    logic [0:0]  d_source;
    logic [0:0]  d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        d_valid;
    logic        d_ready;
    int          n_chk;
    int          n_pass;

    tl_ul_sram_slave dut (
        .clk_i(clk), .rst_ni(rst_n),
        .a_opcode_i(a_opcode), .a_param_i(a_param), .a_size_i(a_size),
        .a_source_i(a_source), .a_address_i(a_address), .a_mask_i(a_mask),
        .a_data_i(a_data), .a_valid_i(a_valid), .a_ready_o(a_ready),
        .d_opcode_o(d_opcode), .d_param_o(d_param), .d_size_o(d_size),
        .d_source_o(d_source), .d_sink_o(d_sink), .d_data_o(d_data),
        .d_error_o(d_error), .d_valid_o(d_valid), .d_ready_i(d_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic drive(input logic [2:0] op, input logic [1:0] sz, input logic src,
                         input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data);
        a_opcode  = op;
        a_size    = sz;
        a_source  = src;
        a_address = addr;
        a_mask    = mask;
        a_data    = data;
        a_valid   = 1'b1;
    endtask

    task automatic req(input string tag, input logic [2:0] op, input logic [1:0] sz, input logic src,
                       input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data,
                       input logic [2:0] e_op, input logic e_err, input logic [31:0] e_data);
        @(negedge clk);
        d_ready = 1'b1;
        drive(op, sz, src, addr, mask, data);
        check({tag, ".a_ready"}, a_ready, 1);
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        check({tag, ".d_valid"}, d_valid, 1);
        check({tag, ".d_opcode"}, d_opcode, e_op);
        check({tag, ".d_error"}, d_error, e_err);
        check({tag, ".d_data"}, d_data, e_data);
        check({tag, ".d_source"}, d_source, src);
        check({tag, ".d_size"}, d_size, sz);
        check({tag, ".d_param"}, {d_param, d_sink}, 0);
    endtask

    initial begin
        n_chk   = 0;
        n_pass  = 0;
        rst_n   = 1'b0;
        d_ready = 1'b1;
        a_param = 3'd0;
        drive(3'd4, 2'd2, 1'b0, 32'h0, 4'hF, 32'h0);
        a_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.d_valid", d_valid, 0);
        check("rst.a_ready", a_ready, 0);
        check("rst.d_opcode", d_opcode, 0);
        check("rst.d_data", d_data, 0);
        check("rst.d_error", d_error, 0);
        check("rst.d_size_src", {d_size, d_source}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("idle.a_ready", a_ready, 1);

        req("put_full", 3'd0, 2'd2, 1'b0, 32'h10, 4'hF, 32'hDEADBEEF, 3'd0, 1'b0, 32'h0);
        req("get_full", 3'd4, 2'd2, 1'b1, 32'h10, 4'hF, 32'h0, 3'd1, 1'b0, 32'hDEADBEEF);
        req("put_part", 3'd1, 2'd2, 1'b0, 32'h10, 4'h6, 32'h00ABCD00, 3'd0, 1'b0, 32'h0);
        req("get_part", 3'd4, 2'd2, 1'b0, 32'h10, 4'hF, 32'h0, 3'd1, 1'b0, 32'hDEABCDEF);

        req("err_align", 3'd4, 2'd2, 1'b0, 32'h12, 4'hF, 32'h0, 3'd1, 1'b1, 32'h0);
        req("err_range", 3'd4, 2'd2, 1'b1, 32'h1000, 4'hF, 32'h0, 3'd1, 1'b1, 32'h0);
        req("err_op2", 3'd2, 2'd2, 1'b0, 32'h10, 4'hF, 32'h11111111, 3'd0, 1'b1, 32'h0);
        req("err_size3", 3'd0, 2'd3, 1'b0, 32'h10, 4'hF, 32'h22222222, 3'd0, 1'b1, 32'h0);
        req("err_full_mask", 3'd0, 2'd2, 1'b0, 32'h10, 4'h7, 32'h33333333, 3'd0, 1'b1, 32'h0);
        req("err_part_mask", 3'd1, 2'd0, 1'b0, 32'h10, 4'h3, 32'h44444444, 3'd0, 1'b1, 32'h0);
        req("get_unchanged", 3'd4, 2'd2, 1'b0, 32'h10, 4'hF, 32'h0, 3'd1, 1'b0, 32'hDEABCDEF);
        req("part_empty", 3'd1, 2'd0, 1'b1, 32'h11, 4'h0, 32'h66666666, 3'd0, 1'b0, 32'h0);
        req("put_byte", 3'd0, 2'd0, 1'b0, 32'h13, 4'h8, 32'h55000000, 3'd0, 1'b0, 32'h0);
        req("get_byte", 3'd4, 2'd2, 1'b1, 32'h10, 4'hF, 32'h0, 3'd1, 1'b0, 32'h55ABCDEF);

        @(negedge clk);
        d_ready = 1'b0;
        drive(3'd4, 2'd2, 1'b0, 32'h10, 4'hF, 32'h0);
        for (int c = 0; c < 3; c++) begin
            #1;
            check("bp.a_ready", a_ready, 0);
            check("bp.d_valid", d_valid, 1);
            check("bp.hold", {d_opcode, d_source, d_error, d_data}, {3'd1, 1'b1, 1'b0, 32'h55ABCDEF});
            @(negedge clk);
        end
        d_ready = 1'b1;
        #1;
        check("bp.release_ready", a_ready, 1);
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        check("bp.new_resp", {d_valid, d_opcode, d_source, d_data}, {1'b1, 3'd1, 1'b0, 32'h55ABCDEF});

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive(3'd0, 2'd2, 1'(i), 32'(i * 4), 4'hF, 32'hA0000000 | 32'(i));
            @(posedge clk);
            #1;
            check("tput_put", {d_valid, d_opcode, d_source, d_error}, {1'b1, 3'd0, 1'(i), 1'b0});
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive(3'd4, 2'd2, 1'(i), 32'(i * 4), 4'hF, 32'h0);
            check("tput_ready", a_ready, 1);
            @(posedge clk);
            #1;
            check("tput_get", {d_valid, d_source, d_data}, {1'b1, 1'(i), 32'hA0000000 | 32'(i)});
        end
        @(negedge clk);
        a_valid = 1'b0;
        @(posedge clk);
        #1;
        check("drain.d_valid", d_valid, 0);

        req("pre_rst", 3'd4, 2'd2, 1'b1, 32'h8, 4'hF, 32'h0, 3'd1, 1'b0, 32'hA0000002);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst.d_valid", d_valid, 0);
        check("midrst.a_ready", a_ready, 0);
        check("midrst.d_data", d_data, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        req("post_rst", 3'd4, 2'd2, 1'b0, 32'h4, 4'hF, 32'h0, 3'd1, 1'b0, 32'hA0000001);
        req("post_rst_hi", 3'd4, 2'd2, 1'b1, 32'h1C, 4'hF, 32'h0, 3'd1, 1'b0, 32'hA0000007);

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
